// File: rtl/timer_sample_sched.sv
// Round-robin timestamp scheduler: arbitrates N_REQ requesters onto a shared
// timer_core sample strobe and returns the captured value with a one-hot ack.
module timer_sample_sched #(
  parameter int N_REQ   = 4,
  parameter int TIMER_W = 64
) (
  input  logic               clk_i,
  input  logic               cke_i,
  input  logic               arst_n_i,
  input  logic [N_REQ-1:0]   req_i,
  output logic [N_REQ-1:0]   ack_o,
  output logic [TIMER_W-1:0] data_o,
  output logic               busy_o,
  input  logic               en_set_i,
  input  logic               en_clr_i,
  output logic               timer_enable_o,
  output logic               timer_sample_o,
  input  logic [TIMER_W-1:0] timer_value_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [N_REQ-1:0] ack_d;

  // Round-robin search: first asserted request at or after ptr_q, wrapping.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!pick_vld && req_i[idx]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (pick_vld) state_d = S_SAMPLE;
      S_SAMPLE:  state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d = '0;
    if (state_d == S_RESP) ack_d[grant_q] = 1'b1;
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      grant_q        <= '0;
      ack_o          <= '0;
      data_o         <= '0;
      busy_o         <= 1'b0;
      timer_enable_o <= 1'b0;
      timer_sample_o <= 1'b0;
    end else if (cke_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      busy_o         <= (state_d != S_IDLE);
      timer_sample_o <= (state_d == S_SAMPLE);
      ack_o          <= ack_d;
      if (state_q == S_IDLE && pick_vld) begin
        grant_q <= pick;
        ptr_q   <= (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
      end
      if (state_q == S_CAPTURE) data_o <= timer_value_i;
      // Clear has priority over set when both pulse together.
      if (en_clr_i)      timer_enable_o <= 1'b0;
      else if (en_set_i) timer_enable_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_sample_sched.sv
// Directed bench for timer_sample_sched with a small timer_core model that
// latches a free-running count on the sample strobe.
module tb_timer_sample_sched;

  logic        clk_i = 1'b0;
  logic        cke_i;
  logic        arst_n_i;
  logic [3:0]  req_i;
  logic [3:0]  ack_o;
  logic [63:0] data_o;
  logic        busy_o;
  logic        en_set_i;
  logic        en_clr_i;
  logic        timer_enable_o;
  logic        timer_sample_o;
  logic [63:0] timer_value_i;

  timer_sample_sched #(.N_REQ(4), .TIMER_W(64)) dut (
    .clk_i          (clk_i),
    .cke_i          (cke_i),
    .arst_n_i       (arst_n_i),
    .req_i          (req_i),
    .ack_o          (ack_o),
    .data_o         (data_o),
    .busy_o         (busy_o),
    .en_set_i       (en_set_i),
    .en_clr_i       (en_clr_i),
    .timer_enable_o (timer_enable_o),
    .timer_sample_o (timer_sample_o),
    .timer_value_i  (timer_value_i)
  );

  always #5 clk_i = ~clk_i;

  // timer_core model: count runs while enabled, value register loads on strobe.
  logic [63:0] cnt = 64'd1000;
  logic [63:0] tval = 64'd0;
  assign timer_value_i = tval;
  always @(posedge clk_i) begin
    if (timer_enable_o) cnt <= cnt + 64'd1;
    if (timer_sample_o) tval <= cnt;
  end

  int          cyc = 0;
  int          n_strobe = 0;
  int          strobe_cyc = 0;
  logic [63:0] exp_val = '0;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i) begin
    if (timer_sample_o) begin
      n_strobe   = n_strobe + 1;
      strobe_cyc = cyc;
      exp_val    = cnt;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] last_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Waits for any ack, checks which one and how many cycles it took, then drops that request.
  task automatic wait_ack(input string tag, input logic [3:0] exp_ack, input int exp_wait);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (ack_o == 4'b0 && n < 50);
    check({tag, "_ack"}, 64'(ack_o), 64'(exp_ack));
    if (exp_wait > 0) check({tag, "_lat"}, 64'(n), 64'(exp_wait));
    last_data = data_o;
    req_i = req_i & ~ack_o;
  endtask

  task automatic do_reset();
    arst_n_i = 1'b0;
    req_i    = '0;
    en_set_i = 1'b0;
    en_clr_i = 1'b0;
    cke_i    = 1'b1;
    tick(3);
    arst_n_i = 1'b1;
    tick(1);
  endtask

  task automatic pulse_en(input logic set, input logic clr);
    en_set_i = set;
    en_clr_i = clr;
    tick(1);
    en_set_i = 1'b0;
    en_clr_i = 1'b0;
  endtask

  logic [63:0] d1, d2, prev;
  int          s1, s2, strobes_before;
  logic        acc;

  initial begin
    // Reset and idle
    do_reset();
    check("rst_ack", 64'(ack_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_en", 64'(timer_enable_o), 64'd0);
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      acc = acc | busy_o | timer_sample_o | (|ack_o);
    end
    check("idle_activity", 64'(acc), 64'd0);
    check("idle_strobes", 64'(n_strobe), 64'd0);
    check("idle_data", data_o, 64'd0);

    // Single request with exact edge timing
    pulse_en(1'b1, 1'b0);
    check("en_set", 64'(timer_enable_o), 64'd1);
    req_i = 4'b0010;
    tick(1);
    check("sgl_strobe", 64'(timer_sample_o), 64'd1);
    check("sgl_busy", 64'(busy_o), 64'd1);
    tick(1);
    check("sgl_strobe_off", 64'(timer_sample_o), 64'd0);
    tick(1);
    check("sgl_ack", 64'(ack_o), 64'b0010);
    check("sgl_data", data_o, exp_val);
    req_i = '0;
    d1 = data_o;
    s1 = strobe_cyc;
    tick(1);
    check("sgl_ack_off", 64'(ack_o), 64'd0);
    tick(1000);
    req_i = 4'b0010;
    wait_ack("sgl2", 4'b0010, 3);
    d2 = last_data;
    s2 = strobe_cyc;
    check("sgl_gap", d2 - d1, 64'(s2 - s1));

    // All four from reset: order 0..3, 4 cycles apart, values 4 apart
    do_reset();
    pulse_en(1'b1, 1'b0);
    req_i = 4'b1111;
    wait_ack("all0", 4'b0001, 3);
    prev = last_data;
    for (int k = 1; k < 4; k++) begin
      wait_ack($sformatf("all%0d", k), 4'(1 << k), 4);
      check($sformatf("all%0d_delta", k), last_data - prev, 64'd4);
      prev = last_data;
    end

    // Fairness: after req 2, req 3 wins over req 0
    tick(2);
    req_i = 4'b0100;
    wait_ack("fair_r2", 4'b0100, 3);
    tick(1);
    req_i = 4'b1001;
    wait_ack("fair_r3", 4'b1000, 3);
    wait_ack("fair_r0", 4'b0001, 4);

    // Enable control: clear wins; disabled samples are equal
    tick(1);
    pulse_en(1'b1, 1'b1);
    check("en_clr_wins", 64'(timer_enable_o), 64'd0);
    req_i = 4'b0010;
    wait_ack("dis_a", 4'b0010, 3);
    d1 = last_data;
    tick(5);
    req_i = 4'b0100;
    wait_ack("dis_b", 4'b0100, 3);
    check("dis_equal", last_data, d1);

    // Clock-enable stall during CAPTURE
    pulse_en(1'b1, 1'b0);
    strobes_before = n_strobe;
    req_i = 4'b0001;
    tick(1);
    check("stall_strobe", 64'(timer_sample_o), 64'd1);
    tick(1);
    cke_i = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      acc = acc | timer_sample_o | (|ack_o);
    end
    check("stall_quiet", 64'(acc), 64'd0);
    cke_i = 1'b1;
    tick(1);
    check("stall_ack", 64'(ack_o), 64'b0001);
    check("stall_data", data_o, exp_val);
    check("stall_strobes", 64'(n_strobe - strobes_before), 64'd1);
    req_i = '0;
    tick(2);

    // Reset during RESP aborts; pointer returns to 0
    req_i = 4'b0100;
    tick(3);
    arst_n_i = 1'b0;
    #1;
    check("arst_ack", 64'(ack_o), 64'd0);
    check("arst_data", data_o, 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    tick(2);
    arst_n_i = 1'b1;
    req_i = 4'b1100;
    wait_ack("arst_r2", 4'b0100, 3);
    wait_ack("arst_r3", 4'b1000, 4);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
